// File: rtl/rotating_banner_gen_pkg.sv
// Shared definitions for the rotating banner: scroll direction encoding
// and the circular index helper used to move the window head.
package banner_pkg;

    // Scroll direction as presented on the dir input.
    typedef enum logic {
        DIR_LEFT  = 1'b0,   // head moves to the next word (ptr+1)
        DIR_RIGHT = 1'b1    // head moves to the previous word (ptr-1)
    } dir_e;

    // One step of a circular index over 0..n-1 in the requested direction.
    // Wrap is handled by explicit compares so no divider is ever built.
    function automatic int unsigned wrap_idx(input int unsigned idx,
                                             input logic        dir,
                                             input int unsigned n);
        int unsigned res;
        res = idx;
        if (dir == DIR_RIGHT) begin
            res = (idx == 0) ? n - 1 : idx - 1;
        end else begin
            res = (idx == n - 1) ? 0 : idx + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rotating_banner_gen_if.sv
// Control/data bundle between the message source and the banner generator.
// The master drives the scroll controls and the word buffer contents; the
// banner (slave) returns the visible window, its head index and the tick.
interface rotating_banner_gen_if #(
    parameter int DIGIT_W   = 4,
    parameter int NUM_WORDS = 10,
    parameter int NUM_DISP  = 4
);
    localparam int PTR_W = $clog2(NUM_WORDS);

    logic                          en;
    logic                          pause;
    logic                          dir;
    logic                          step;
    logic                          load;
    logic [NUM_WORDS*DIGIT_W-1:0]  words;
    logic [NUM_DISP*DIGIT_W-1:0]   disp;
    logic [PTR_W-1:0]              ptr;
    logic                          tick;

    modport master (
        output en, pause, dir, step, load, words,
        input  disp, ptr, tick
    );

    modport slave (
        input  en, pause, dir, step, load, words,
        output disp, ptr, tick
    );

endinterface

// File: rtl/rotating_banner_gen_prescaler.sv
// Scroll-rate prescaler: counts run cycles and raises adv on the cycle in
// which the count reaches TICK_DIV-1. clr restarts the count from zero.
module banner_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic adv
);
    import banner_pkg::*;

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_term;

    assign w_term = (r_cnt == CNT_W'(TICK_DIV - 1));
    // adv is combinational so the advance lands on the same edge the
    // counter wraps; the top registers everything derived from it.
    assign adv    = run & w_term;

    // Run-cycle counter; holds while run is low, restarts on clr.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated with <= so every register sees
        // the pre-edge value of its neighbours, independent of block order.
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= w_term ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/rotating_banner_gen.sv
// Rotating banner generator: a loadable circular buffer of NUM_WORDS symbols
// with a NUM_DISP-wide registered window that scrolls automatically at a
// prescaled rate or by manual step, in either direction.
module rotating_banner_gen #(
    parameter int DIGIT_W   = 4,
    parameter int NUM_WORDS = 10,
    parameter int NUM_DISP  = 4,
    parameter int TICK_DIV  = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    rotating_banner_gen_if.slave  bus
);
    import banner_pkg::*;

    localparam int PTR_W = $clog2(NUM_WORDS);

    if (NUM_WORDS < NUM_DISP || NUM_WORDS < 2 || TICK_DIV < 1) begin : g_bad_params
        $error("rotating_banner_gen: need NUM_WORDS >= NUM_DISP, NUM_WORDS >= 2, TICK_DIV >= 1");
    end

    logic [DIGIT_W-1:0]           r_buf     [NUM_WORDS];
    logic [DIGIT_W-1:0]           w_buf_nxt [NUM_WORDS];
    logic [PTR_W-1:0]             r_ptr;
    logic [PTR_W-1:0]             w_ptr_nxt;
    logic [NUM_DISP*DIGIT_W-1:0]  r_disp;
    logic [NUM_DISP*DIGIT_W-1:0]  w_disp_nxt;
    logic                         r_tick;
    logic                         w_run;
    logic                         w_presc_adv;
    logic                         w_step_adv;
    logic                         w_adv;

    assign w_run      = bus.en & ~bus.pause;
    assign w_step_adv = ~bus.en & bus.step;
    // Load wins over both advance sources in the same cycle.
    assign w_adv      = ~bus.load & (w_presc_adv | w_step_adv);

    banner_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (w_run),
        .clr   (bus.load),
        .adv   (w_presc_adv)
    );

    // Next buffer contents and window head: load, advance or hold.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        w_buf_nxt = r_buf;
        w_ptr_nxt = r_ptr;
        if (bus.load) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                w_buf_nxt[i] = bus.words[i*DIGIT_W +: DIGIT_W];
            end
            w_ptr_nxt = '0;
        end else if (w_adv) begin
            w_ptr_nxt = PTR_W'(wrap_idx(32'(r_ptr), bus.dir, NUM_WORDS));
        end
    end

    // Window built from the next-state buffer/head so disp never lags ptr;
    // the top slot holds the head word, later words fill lower slots.
    always_comb begin
        logic [PTR_W:0] w_sum;
        w_sum      = '0;
        w_disp_nxt = '0;
        for (int k = 0; k < NUM_DISP; k++) begin
            w_sum = {1'b0, w_ptr_nxt} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(NUM_WORDS)) begin
                w_sum = w_sum - (PTR_W+1)'(NUM_WORDS);
            end
            w_disp_nxt[(NUM_DISP-1-k)*DIGIT_W +: DIGIT_W] = w_buf_nxt[w_sum[PTR_W-1:0]];
        end
    end

    // State registers: buffer, head, window and advance tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the buffer is cleared on reset because its contents are
            // visible on disp immediately; an unreset buffer would show X.
            for (int i = 0; i < NUM_WORDS; i++) begin
                r_buf[i] <= '0;
            end
            r_ptr  <= '0;
            r_disp <= '0;
            r_tick <= 1'b0;
        end else begin
            r_buf  <= w_buf_nxt;
            r_ptr  <= w_ptr_nxt;
            r_disp <= w_disp_nxt;
            r_tick <= w_adv;
        end
    end

    assign bus.disp = r_disp;
    assign bus.ptr  = r_ptr;
    assign bus.tick = r_tick;

endmodule

// File: tb/tb_rotating_banner_gen.sv
// Self-checking bench for rotating_banner_gen with TICK_DIV=4: a table of
// directed vectors, hand-written corner sequences, and a randomized run,
// all compared every cycle against a behavioural model of the banner.
module tb_rotating_banner_gen;

    localparam int DIGIT_W   = 4;
    localparam int NUM_WORDS = 10;
    localparam int NUM_DISP  = 4;
    localparam int TICK_DIV  = 4;
    localparam int WW        = NUM_WORDS * DIGIT_W;
    localparam int DW        = NUM_DISP * DIGIT_W;

    localparam logic [WW-1:0] W_UP   = 40'h98_7654_3210;  // word i = i
    localparam logic [WW-1:0] W_DOWN = 40'h01_2345_6789;  // word i = 9-i

    logic clk;
    logic reset;

    rotating_banner_gen_if #(
        .DIGIT_W   (DIGIT_W),
        .NUM_WORDS (NUM_WORDS),
        .NUM_DISP  (NUM_DISP)
    ) bus ();

    rotating_banner_gen #(
        .DIGIT_W   (DIGIT_W),
        .NUM_WORDS (NUM_WORDS),
        .NUM_DISP  (NUM_DISP),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: plain arrays and modulo arithmetic.
    int m_buf [NUM_WORDS];
    int m_ptr;
    int m_cnt;
    int m_tick;

    typedef struct {
        logic           en, pause, dir, step, load;
        logic [WW-1:0]  words;
        int             exp_ptr;
        int             exp_tick;
        logic [DW-1:0]  exp_disp;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_disp();
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_DISP; k++) begin
            d = d | (DW'(m_buf[(m_ptr + k) % NUM_WORDS]) << ((NUM_DISP - 1 - k) * DIGIT_W));
        end
        return d;
    endfunction

    task automatic model_edge();
        int adv;
        adv = 0;
        if (reset) begin
            for (int i = 0; i < NUM_WORDS; i++) m_buf[i] = 0;
            m_ptr = 0; m_cnt = 0; m_tick = 0;
        end else if (bus.load) begin
            for (int i = 0; i < NUM_WORDS; i++) m_buf[i] = int'((bus.words >> (i * DIGIT_W)) & 40'hF);
            m_ptr = 0; m_cnt = 0; m_tick = 0;
        end else begin
            if (bus.en && !bus.pause) begin
                if (m_cnt == TICK_DIV - 1) begin m_cnt = 0; adv = 1; end
                else m_cnt++;
            end
            if (!bus.en && bus.step) adv = 1;
            if (adv != 0) m_ptr = bus.dir ? (m_ptr + NUM_WORDS - 1) % NUM_WORDS : (m_ptr + 1) % NUM_WORDS;
            m_tick = adv;
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("model_ptr",  64'(bus.ptr),  64'(m_ptr));
        check("model_tick", 64'(bus.tick), 64'(m_tick));
        check("model_disp", 64'(bus.disp), 64'(model_disp()));
    endtask

    task automatic idle_inputs();
        reset = 1'b0; bus.en = 1'b0; bus.pause = 1'b0; bus.dir = 1'b0;
        bus.step = 1'b0; bus.load = 1'b0;
    endtask

    task automatic do_load(input logic [WW-1:0] w);
        bus.load = 1'b1; bus.words = w;
        cyc();
        bus.load = 1'b0;
    endtask

    task automatic do_step();
        bus.step = 1'b1;
        cyc();
        bus.step = 1'b0;
    endtask

    task automatic expect_out(input string name, input int p, input int t, input logic [DW-1:0] d);
        check({name, "_ptr"},  64'(bus.ptr),  64'(p));
        check({name, "_tick"}, 64'(bus.tick), 64'(t));
        check({name, "_disp"}, 64'(bus.disp), 64'(d));
    endtask

    initial begin
        logic [63:0] rnd;

        //          en    pause dir   step  load  words   ptr tick disp
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, W_UP,   0,  0,   16'h0123};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W_DOWN, 0,  0,   16'h0123};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W_DOWN, 0,  0,   16'h0123};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W_DOWN, 0,  0,   16'h0123};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W_DOWN, 1,  1,   16'h1234};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W_DOWN, 1,  0,   16'h1234};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, W_DOWN, 2,  1,   16'h2345};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, W_DOWN, 0,  0,   16'h9876};

        idle_inputs();
        bus.words = '0;
        m_ptr = 0; m_cnt = 0; m_tick = 0;
        for (int i = 0; i < NUM_WORDS; i++) m_buf[i] = 0;

        // Reset state.
        reset = 1'b1;
        cyc();
        cyc();
        expect_out("reset", 0, 0, 16'h0000);
        reset = 1'b0;

        // Directed table: load, first auto advance after 4 run cycles, steps,
        // and load winning over a coincident step.
        for (int v = 0; v < 8; v++) begin
            bus.en = tbl[v].en; bus.pause = tbl[v].pause; bus.dir = tbl[v].dir;
            bus.step = tbl[v].step; bus.load = tbl[v].load; bus.words = tbl[v].words;
            cyc();
            expect_out($sformatf("tbl%0d", v), tbl[v].exp_ptr, tbl[v].exp_tick, tbl[v].exp_disp);
        end
        idle_inputs();

        // Wrap left through all ten words, then one step right.
        do_load(W_UP);
        bus.en = 1'b1; bus.dir = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (c == 28) expect_out("wrap7", 7, 1, 16'h7890);
        end
        expect_out("wrap10", 0, 1, 16'h0123);
        bus.dir = 1'b1;
        for (int c = 0; c < 4; c++) cyc();
        expect_out("dir_right", 9, 1, 16'h9012);
        idle_inputs();

        // Pause with the count at 2: no advance for 10 cycles, then 2 more.
        do_load(W_UP);
        bus.en = 1'b1;
        cyc(); cyc();
        bus.pause = 1'b1;
        for (int c = 0; c < 10; c++) cyc();
        expect_out("paused", 0, 0, 16'h0123);
        bus.pause = 1'b0;
        cyc();
        expect_out("resume1", 0, 0, 16'h0123);
        cyc();
        expect_out("resume2", 1, 1, 16'h1234);
        idle_inputs();

        // Manual steps, a step ignored while en=1, load at terminal count.
        do_load(W_UP);
        for (int s = 1; s <= 3; s++) begin
            do_step();
            check("step_ptr",  64'(bus.ptr),  64'(s));
            check("step_tick", 64'(bus.tick), 64'(1));
            cyc();
            check("step_gap_tick", 64'(bus.tick), 64'(0));
        end
        bus.en = 1'b1; bus.pause = 1'b1;
        do_step();
        expect_out("step_en1", 3, 0, 16'h3456);
        bus.pause = 1'b0;
        cyc(); cyc(); cyc();
        check("pre_tc_ptr", 64'(bus.ptr), 64'(3));
        do_load(W_UP);
        expect_out("load_at_tc", 0, 0, 16'h0123);
        cyc();
        check("post_load_tick", 64'(bus.tick), 64'(0));
        idle_inputs();

        // Reset mid-rotation at ptr=5, then reload descending words.
        for (int s = 0; s < 5; s++) do_step();
        check("pre_reset_ptr", 64'(bus.ptr), 64'(5));
        reset = 1'b1;
        cyc();
        expect_out("mid_reset", 0, 0, 16'h0000);
        reset = 1'b0;
        do_load(W_DOWN);
        expect_out("reload", 0, 0, 16'h9876);

        // Randomized traffic; words churns every cycle but only load may use it.
        for (int c = 0; c < 800; c++) begin
            rnd = {$urandom(), $urandom()};
            bus.words = rnd[WW-1:0];
            reset     = ($urandom_range(0, 99) == 0);
            bus.load  = ($urandom_range(0, 24) == 0);
            bus.en    = ($urandom_range(0, 3) != 0);
            bus.pause = ($urandom_range(0, 4) == 0);
            bus.dir   = ($urandom_range(0, 3) == 0);
            bus.step  = ($urandom_range(0, 2) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
